// File: rtl/mode_pkg.sv
// Shared state encoding for the run/last sequencer and its simulation-only name decode.
package mode_pkg;

  localparam int unsigned StateW = 2;

  typedef logic [StateW-1:0] state_t;

  localparam state_t StIdle = 2'd0;
  localparam state_t StRun  = 2'd1;
  localparam state_t StLast = 2'd2;

`ifndef SYNTHESIS
  function automatic string state_name(state_t s);
    case (s)
      StIdle:  return "IDLE";
      StRun:   return "RUN";
      StLast:  return "LAST";
      default: return "ILLEGAL";
    endcase
  endfunction
`endif

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin pick: first set request at ptr, ptr+1, ... wrapping modulo N.
module rr_pick #(
  parameter  int unsigned N    = 4,
  localparam int unsigned IdxW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [IdxW-1:0] ptr,
  output logic            valid,
  output logic [IdxW-1:0] idx
);

  logic [IdxW-1:0] cand;

  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = '0;
    for (int unsigned i = 0; i < N; i++) begin
      cand = IdxW'((32'(ptr) + i) % N);
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = cand;
      end
    end
  end

endmodule

// File: rtl/mode_arb.sv
// Round-robin arbiter driving a shared IDLE/RUN/LAST sequencer with a run-length timeout.
module mode_arb
  import mode_pkg::*;
#(
  parameter int unsigned N       = 4,
  parameter int unsigned MAX_RUN = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic         run,
  output logic         start,
  output logic         fin,
  output logic         preempt
);

  localparam int unsigned IdxW = $clog2(N);
  localparam int unsigned CntW = $clog2(MAX_RUN);

  state_t          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] ptr_q, ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            pick_valid;
  logic [IdxW-1:0] pick_idx;
  logic            owner_req;
  logic            timeout;
  logic [N-1:0]    gnt_d;
  logic            run_d, start_d, fin_d, preempt_d;

  rr_pick #(
    .N (N)
  ) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  assign owner_req = req[owner_q];
  assign timeout   = (cnt_q == CntW'(MAX_RUN - 1));

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          state_d = StRun;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      StRun: begin
        cnt_d = cnt_q + CntW'(1);
        if (!owner_req || timeout) state_d = StLast;
      end
      StLast: begin
        state_d = StIdle;
        ptr_d   = (owner_q == IdxW'(N - 1)) ? '0 : owner_q + IdxW'(1);
      end
      default: state_d = StIdle;
    endcase
  end

  // Outputs decode the next state so the registered copies line up with state_q.
  always_comb begin
    gnt_d = '0;
    if (state_d != StIdle) gnt_d[owner_d] = 1'b1;
    run_d     = (state_d == StRun);
    start_d   = (state_q == StIdle) && (state_d == StRun);
    fin_d     = (state_d == StLast);
    // A release in the timeout cycle counts as a normal finish, not a preemption.
    preempt_d = (state_q == StRun) && (state_d == StLast) && owner_req && timeout;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      owner_q <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
      gnt     <= '0;
      run     <= 1'b0;
      start   <= 1'b0;
      fin     <= 1'b0;
      preempt <= 1'b0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt     <= gnt_d;
      run     <= run_d;
      start   <= start_d;
      fin     <= fin_d;
      preempt <= preempt_d;
    end
  end

`ifndef SYNTHESIS
  last_to_idle: assert property (@(posedge clk) disable iff (rst)
    (state_q == StLast) |=> (state_q == StIdle))
    else $error("mode_arb: LAST was followed by %s", state_name(state_q));
`endif

endmodule

// File: tb/tb_mode_arb.sv
// Directed bench for mode_arb: stimulus queues expected grants, a negedge monitor scores them.
module tb_mode_arb;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] req = 4'b1111;
  logic [3:0] gnt;
  logic       run, start, fin, preempt;

  typedef struct {
    logic [3:0] gnt;
    int         run_len;
    logic       preempt;
    logic       aborted;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  mode_arb #(
    .N       (4),
    .MAX_RUN (16)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .gnt     (gnt),
    .run     (run),
    .start   (start),
    .fin     (fin),
    .preempt (preempt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [3:0] g, input int len, input logic pre, input logic ab);
    exp_t e;
    e.gnt = g; e.run_len = len; e.preempt = pre; e.aborted = ab;
    exp_q.push_back(e);
  endtask

  // Monitor: outputs seen at negedge reflect the previous posedge; req/rst seen now feed the next.
  initial begin : monitor
    exp_t       e;
    logic       in_grant, after_fin, gnt_bad, rst_prev, aborted;
    logic [3:0] cur_gnt;
    int         run_len, starts, waits;
    in_grant = 1'b0; after_fin = 1'b0; gnt_bad = 1'b0; rst_prev = 1'b1; aborted = 1'b0;
    cur_gnt = '0; run_len = 0; starts = 0; waits = 0;
    forever begin
      @(negedge clk);
      if (rst_prev) begin
        check("reset_outputs", {gnt, run, start, fin, preempt}, 32'h0);
        if (in_grant) begin
          aborted = 1'b1;
          check("queue_nonempty", exp_q.size() != 0, 32'h1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("abort_owner", cur_gnt, e.gnt);
            check("abort_run_len", run_len, e.run_len);
            check("end_kind", aborted, e.aborted);
          end
        end
        in_grant = 1'b0; after_fin = 1'b0; waits = 0;
      end else begin
        if (start && !in_grant) begin
          check("grant_latency", waits, 32'd1);
          waits = 0; in_grant = 1'b1; cur_gnt = gnt; run_len = 0; starts = 0; gnt_bad = 1'b0;
        end
        if (start) starts++;
        if (run) run_len++;
        if (in_grant && gnt !== cur_gnt) gnt_bad = 1'b1;
        if (preempt && !fin) check("preempt_without_fin", preempt, 32'h0);
        if (fin) begin
          aborted = 1'b0;
          check("queue_nonempty", exp_q.size() != 0, 32'h1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("fin_owner", gnt, e.gnt);
            check("fin_run_len", run_len, e.run_len);
            check("fin_preempt", preempt, e.preempt);
            check("end_kind", aborted, e.aborted);
          end
          check("start_pulses", starts, 32'd1);
          check("gnt_stable", gnt_bad, 32'h0);
          check("run_low_in_last", run, 32'h0);
          in_grant = 1'b0; after_fin = 1'b1;
        end else if (after_fin) begin
          check("idle_after_grant", gnt, 32'h0);
          after_fin = 1'b0;
        end
      end
      if (!rst && gnt == 4'b0000 && req != 4'b0000) waits++;
      rst_prev = rst;
    end
  end

  initial begin : stimulus
    logic [3:0] m;

    // Reset held two edges with all requests up; first grant goes to index 0.
    push(4'b0001, 1, 1'b0, 1'b0);
    tick(2);
    rst = 1'b0;
    tick(1);
    req = 4'b0000;
    tick(3);

    // Single release after five RUN cycles (ptr now 1, only requester 2).
    push(4'b0100, 5, 1'b0, 1'b0);
    req = 4'b0100;
    tick(1);
    tick(4);
    req = 4'b0000;
    tick(3);

    // Held request times out, regrants after one IDLE, then releases on the timeout cycle.
    push(4'b0010, 16, 1'b1, 1'b0);
    push(4'b0010, 16, 1'b0, 1'b0);
    req = 4'b0010;
    tick(1);
    tick(15);
    tick(1);
    tick(1);
    tick(1);
    tick(15);
    req = 4'b0000;
    tick(3);

    // Reset on the third RUN cycle aborts; next grant goes to lowest set index.
    push(4'b1000, 3, 1'b0, 1'b1);
    push(4'b0010, 2, 1'b0, 1'b0);
    req = 4'b1000;
    tick(1);
    tick(2);
    rst = 1'b1;
    req = 4'b0110;
    tick(1);
    rst = 1'b0;
    tick(1);
    tick(1);
    req = 4'b0000;
    tick(3);

    // Reset in IDLE returns ptr to 0 for the fairness sweep.
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);

    // Fairness: all request, each owner drops on its third RUN cycle.
    push(4'b0001, 3, 1'b0, 1'b0);
    push(4'b0010, 3, 1'b0, 1'b0);
    push(4'b0100, 3, 1'b0, 1'b0);
    push(4'b1000, 3, 1'b0, 1'b0);
    push(4'b0001, 3, 1'b0, 1'b0);
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      tick(2);
      m = 4'b0001 << (k % 4);
      req = 4'b1111 & ~m;
      tick(1);
      req = (k == 4) ? 4'b0000 : 4'b1111;
      tick(1);
    end
    tick(4);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
